// File: rtl/deserializador.sv
// Serial-to-parallel receiver for start / data / optional even parity / stop frames.
// A frame ends in a one-cycle valid, err_paridad or err_trama pulse.
module deserializador #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             err_paridad,
  output logic             err_trama,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             dir_l;
  logic             mismatch;

  // dir_l = 0: first bit lands in the MSB; dir_l = 1: first bit lands in the LSB.
  always_comb begin
    shreg_next = shreg;
    if (dir_l) shreg_next = {s_in, shreg[WIDTH-1:1]};
    else       shreg_next = {shreg[WIDTH-2:0], s_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      dir_l       <= 1'b0;
      mismatch    <= 1'b0;
      q           <= '0;
      valid       <= 1'b0;
      err_paridad <= 1'b0;
      err_trama   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid       <= 1'b0;
      err_paridad <= 1'b0;
      err_trama   <= 1'b0;
      if (enb) begin
        case (state)
          IDLE: begin
            if (!s_in) begin
              state    <= DATA;
              cnt      <= '0;
              dir_l    <= dir;
              mismatch <= 1'b0;
              busy     <= 1'b1;
            end
          end
          DATA: begin
            shreg <= shreg_next;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST_BIT) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
          PARITY: begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            mismatch <= (s_in != ^shreg);
            state    <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!s_in) begin
              err_trama <= 1'b1;
            end else if (mismatch) begin
              err_paridad <= 1'b1;
            end else begin
              q     <= shreg;
              valid <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
